addsub_4bit_sequencer: RTL and testbench

- Control and capture stage wrapped around the combinational 4-bit adder/subtractor with gate delay.
- Upstream side: accepts operations over a valid/ready handshake, registers them, and drives the operands and mode select into the arithmetic unit.
- Waits a fixed number of clock cycles for the gate-delayed result to settle, then samples the sum, carry and signed overflow.
- Downstream side: presents the captured result over a second valid/ready handshake.

---
 rtl/addsub_4bit_sequencer.sv | 125 ++++++++++++
 tb/tb_addsub_4bit_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_4bit_sequencer.sv
// Launches registered operands into an external gate-delayed adder/subtractor and samples its result SETTLE_CYCLES edges later.
// Accepts a request only in IDLE; the captured result is held in HOLD until out_ready, so upstream stalls meanwhile.
module addsub_4bit_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_sel,
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  output logic       au_sel,
  input  logic [3:0] au_s,
  input  logic       au_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_s,
  output logic       out_cout,
  output logic       out_ovf,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] au_a_q, au_a_d;
  logic [3:0] au_b_q, au_b_d;
  logic       au_sel_q, au_sel_d;
  logic [3:0] out_s_q, out_s_d;
  logic       out_cout_q, out_cout_d;
  logic       out_ovf_q, out_ovf_d;
  logic       ovf;

  // Overflow judged from the registered operands, since those are what the unit saw.
  always_comb begin
    if (au_sel_q) begin
      ovf = (au_a_q[3] != au_b_q[3]) && (au_s[3] != au_a_q[3]);
    end else begin
      ovf = (au_a_q[3] == au_b_q[3]) && (au_s[3] != au_a_q[3]);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    au_a_d     = au_a_q;
    au_b_d     = au_b_q;
    au_sel_d   = au_sel_q;
    out_s_d    = out_s_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          au_a_d   = in_a;
          au_b_d   = in_b;
          au_sel_d = in_sel;
          cnt_d    = SETTLE_M1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          out_s_d    = au_s;
          out_cout_d = au_cout;
          out_ovf_d  = ovf;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      au_a_q     <= 4'd0;
      au_b_q     <= 4'd0;
      au_sel_q   <= 1'b0;
      out_s_q    <= 4'd0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      au_a_q     <= au_a_d;
      au_b_q     <= au_b_d;
      au_sel_q   <= au_sel_d;
      out_s_q    <= out_s_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign au_sel    = au_sel_q;
  assign out_s     = out_s_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_addsub_4bit_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE_CYCLES 3 and 1) each driving a behavioural adder/subtractor.
module tb_addsub_4bit_sequencer;

  typedef struct packed {
    logic [3:0] s;
    logic       c;
    logic       v;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  res_t sb3[$];
  res_t sb1[$];

  logic       d3_in_valid, d3_in_ready, d3_in_sel, d3_au_sel, d3_au_cout;
  logic [3:0] d3_in_a, d3_in_b, d3_au_a, d3_au_b, d3_au_s, d3_out_s;
  logic       d3_out_valid, d3_out_ready, d3_out_cout, d3_out_ovf, d3_busy;

  logic       d1_in_valid, d1_in_ready, d1_in_sel, d1_au_sel, d1_au_cout;
  logic [3:0] d1_in_a, d1_in_b, d1_au_a, d1_au_b, d1_au_s, d1_out_s;
  logic       d1_out_valid, d1_out_ready, d1_out_cout, d1_out_ovf, d1_busy;

  assign {d3_au_cout, d3_au_s} = d3_au_sel ? ({1'b0, d3_au_a} + {1'b0, ~d3_au_b} + 5'd1)
                                           : ({1'b0, d3_au_a} + {1'b0, d3_au_b});
  assign {d1_au_cout, d1_au_s} = d1_au_sel ? ({1'b0, d1_au_a} + {1'b0, ~d1_au_b} + 5'd1)
                                           : ({1'b0, d1_au_a} + {1'b0, d1_au_b});

  addsub_4bit_sequencer #(.SETTLE_CYCLES(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_a(d3_in_a), .in_b(d3_in_b), .in_sel(d3_in_sel),
    .au_a(d3_au_a), .au_b(d3_au_b), .au_sel(d3_au_sel),
    .au_s(d3_au_s), .au_cout(d3_au_cout),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_s(d3_out_s), .out_cout(d3_out_cout), .out_ovf(d3_out_ovf),
    .busy(d3_busy)
  );

  addsub_4bit_sequencer #(.SETTLE_CYCLES(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_a(d1_in_a), .in_b(d1_in_b), .in_sel(d1_in_sel),
    .au_a(d1_au_a), .au_b(d1_au_b), .au_sel(d1_au_sel),
    .au_s(d1_au_s), .au_cout(d1_au_cout),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_s(d1_out_s), .out_cout(d1_out_cout), .out_ovf(d1_out_ovf),
    .busy(d1_busy)
  );

  // Reference: unsigned sum for carry, signed integer range for overflow.
  function automatic res_t exp_res(input logic [3:0] a, input logic [3:0] b, input logic sel);
    int ua, ub, sa, sbv, u, r;
    res_t e;
    ua  = int'(a);
    ub  = int'(b);
    sa  = a[3] ? ua - 16 : ua;
    sbv = b[3] ? ub - 16 : ub;
    u   = sel ? (ua + (15 - ub) + 1) : (ua + ub);
    r   = sel ? (sa - sbv) : (sa + sbv);
    e.s = 4'(u % 16);
    e.c = (u > 15);
    e.v = (r > 7) || (r < -8);
    return e;
  endfunction

  task automatic launch3(input logic [3:0] a, input logic [3:0] b, input logic sel);
    @(negedge clk);
    d3_in_a = a; d3_in_b = b; d3_in_sel = sel; d3_in_valid = 1'b1;
    sb3.push_back(exp_res(a, b, sel));
    @(posedge clk);
    @(negedge clk);
    d3_in_valid = 1'b0;
  endtask

  task automatic wait3(output int n);
    n = 0;
    while (!d3_out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    d3_in_valid = 0; d3_in_a = 0; d3_in_b = 0; d3_in_sel = 0; d3_out_ready = 0;
    d1_in_valid = 0; d1_in_a = 0; d1_in_b = 0; d1_in_sel = 0; d1_out_ready = 0;
    #1;
    tests++;
    if ({d3_au_a, d3_au_b, d3_au_sel, d3_out_s, d3_out_cout, d3_out_ovf, d3_out_valid, d3_busy} !== 16'd0) begin
      fails++;
      $display("FAIL reset_outputs: got a=%h b=%h sel=%b s=%h c=%b v=%b ov=%b busy=%b, want all 0",
               d3_au_a, d3_au_b, d3_au_sel, d3_out_s, d3_out_cout, d3_out_ovf, d3_out_valid, d3_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (d3_in_ready !== 1'b1 || d1_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", d3_in_ready, d1_in_ready);
    end
  endtask

  task automatic test_add_sub;
    logic [3:0] ta[3] = '{4'd5, 4'h3, 4'h7};
    logic [3:0] tb[3] = '{4'd3, 4'h5, 4'h8};
    logic       ts[3] = '{1'b0, 1'b1, 1'b1};
    res_t       want[3] = '{'{4'h8, 1'b0, 1'b1}, '{4'hE, 1'b0, 1'b0}, '{4'hF, 1'b0, 1'b1}};
    res_t e;
    int n;
    for (int i = 0; i < 3; i++) begin
      launch3(ta[i], tb[i], ts[i]);
      wait3(n);
      e = sb3.pop_front();
      tests++;
      if (n != 3) begin
        fails++;
        $display("FAIL addsub_latency[%0d]: got %0d edges, want 3", i, n);
      end
      tests++;
      if ({d3_out_s, d3_out_cout, d3_out_ovf} !== want[i] || e !== want[i]) begin
        fails++;
        $display("FAIL addsub_result[%0d]: got s=%h c=%b v=%b, want s=%h c=%b v=%b",
                 i, d3_out_s, d3_out_cout, d3_out_ovf, want[i].s, want[i].c, want[i].v);
      end
      @(negedge clk);
      d3_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d3_out_ready = 1'b0;
      tests++;
      if (d3_out_valid !== 1'b0 || d3_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL addsub_release[%0d]: got valid=%b ready=%b, want 0/1", i, d3_out_valid, d3_in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    res_t e;
    int n;
    int bad;
    launch3(4'h6, 4'h6, 1'b0);
    wait3(n);
    e = sb3.pop_front();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      d3_in_valid = i[0];
      d3_in_a = 4'h1; d3_in_b = 4'h2; d3_in_sel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (d3_out_valid !== 1'b1 || d3_in_ready !== 1'b0 ||
          {d3_out_s, d3_out_cout, d3_out_ovf} !== e || d3_au_a !== 4'h6) bad++;
    end
    d3_in_valid = 1'b0;
    tests++;
    if (bad != 0 || n != 3) begin
      fails++;
      $display("FAIL backpressure_hold: got %0d bad cycles latency %0d s=%h, want 0 bad latency 3 s=%h",
               bad, n, d3_out_s, e.s);
    end
    d3_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d3_out_ready = 1'b0;
    tests++;
    if (d3_in_ready !== 1'b1 || d3_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_release: got ready=%b valid=%b, want 1/0", d3_in_ready, d3_out_valid);
    end
    d3_in_a = 4'h9; d3_in_b = 4'h4; d3_in_sel = 1'b1; d3_in_valid = 1'b1;
    sb3.push_back(exp_res(4'h9, 4'h4, 1'b1));
    @(posedge clk);
    @(negedge clk);
    d3_in_valid = 1'b0;
    tests++;
    if (d3_busy !== 1'b1 || d3_au_a !== 4'h9) begin
      fails++;
      $display("FAIL backpressure_next_accept: got busy=%b au_a=%h, want 1/9", d3_busy, d3_au_a);
    end
    wait3(n);
    e = sb3.pop_front();
    tests++;
    if (n != 3 || {d3_out_s, d3_out_cout, d3_out_ovf} !== e) begin
      fails++;
      $display("FAIL backpressure_next_result: got lat=%0d s=%h c=%b v=%b, want lat=3 s=%h c=%b v=%b",
               n, d3_out_s, d3_out_cout, d3_out_ovf, e.s, e.c, e.v);
    end
    d3_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d3_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    res_t e;
    int n;
    logic [3:0] a, b;
    logic s;
    d3_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      launch3(a, b, s);
      wait3(n);
      e = sb3.pop_front();
      tests++;
      if (n != 3 || {d3_out_s, d3_out_cout, d3_out_ovf} !== e) begin
        fails++;
        $display("FAIL back_to_back[%0d] %h %s %h: got lat=%0d s=%h c=%b v=%b, want lat=3 s=%h c=%b v=%b",
                 i, a, s ? "-" : "+", b, n, d3_out_s, d3_out_cout, d3_out_ovf, e.s, e.c, e.v);
      end
    end
    @(posedge clk);
    @(negedge clk);
    d3_out_ready = 1'b0;
  endtask

  task automatic test_settle_one;
    res_t e;
    int n;
    @(negedge clk);
    d1_in_a = 4'hF; d1_in_b = 4'h1; d1_in_sel = 1'b0; d1_in_valid = 1'b1;
    sb1.push_back(exp_res(4'hF, 4'h1, 1'b0));
    @(posedge clk);
    @(negedge clk);
    d1_in_valid = 1'b0;
    n = 0;
    while (!d1_out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    e = sb1.pop_front();
    tests++;
    if (n != 1) begin
      fails++;
      $display("FAIL settle_one_latency: got %0d edges, want 1", n);
    end
    tests++;
    if ({d1_out_s, d1_out_cout, d1_out_ovf} !== 6'b0000_1_0 || e !== 6'b0000_1_0) begin
      fails++;
      $display("FAIL settle_one_result: got s=%h c=%b v=%b, want s=0 c=1 v=0", d1_out_s, d1_out_cout, d1_out_ovf);
    end
    d1_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d1_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_settle;
    res_t e;
    int n;
    int seen;
    launch3(4'hB, 4'h6, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb3.pop_front());
    tests++;
    if ({d3_au_a, d3_au_b, d3_au_sel, d3_out_valid, d3_busy} !== 11'd0) begin
      fails++;
      $display("FAIL midreset_async: got a=%h b=%h sel=%b valid=%b busy=%b, want all 0",
               d3_au_a, d3_au_b, d3_au_sel, d3_out_valid, d3_busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d3_out_valid !== 1'b0 || d3_busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midreset_discard: got %0d cycles with valid/busy set, want 0", seen);
    end
    launch3(4'h2, 4'h9, 1'b1);
    wait3(n);
    e = sb3.pop_front();
    tests++;
    if (n != 3 || {d3_out_s, d3_out_cout, d3_out_ovf} !== e) begin
      fails++;
      $display("FAIL midreset_next: got lat=%0d s=%h c=%b v=%b, want lat=3 s=%h c=%b v=%b",
               n, d3_out_s, d3_out_cout, d3_out_ovf, e.s, e.c, e.v);
    end
    d3_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d3_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_backpressure();
    test_back_to_back();
    test_settle_one();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
